ysyx_22040895_lsu: RTL and testbench

//  Parametrised load/store unit between EXU and WBU; multi-cycle successor of the single-cycle DPI memory stage.

---
 rtl/ysyx_22040895_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_22040895_lsu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | Module   : ysyx_22040895_lsu                                                                  |
// | Brief    : Multi-cycle load/store unit with alignment check, byte strobes and load extension. |
// |            Optional watchdog enabled by defining YSYX_22040895_LSU_TIMEOUT_EN.                |
// | Revision : 1.0 - initial release                                                              |
// +----------------------------------------------------------------------------------------------+

module ysyx_22040895_lsu #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sl,
  input  logic [1:0]        in_munit,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_wmdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_wdata,
  output logic              out_exc,
  output logic [1:0]        out_cause,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  input  logic              mem_resp_err
);

  localparam int STRB = XLEN / 8;
  localparam int OFFW = $clog2(STRB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   bwdata_q, bwdata_d;
  logic [STRB-1:0]   strb_q, strb_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              exc_q, exc_d;
  logic [1:0]        cause_q, cause_d;
  logic [1:0]        munit_q, munit_d;
  logic              uns_q, uns_d;
  logic [OFFW-1:0]   off_q, off_d;

  logic              w_is_mem;
  logic              w_misal;
  logic [OFFW-1:0]   w_in_off;
  logic [7:0]        w_bmask;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_lmask;
  logic              w_sign;
  logic [XLEN-1:0]   w_ext;
  logic              w_timeout;

  assign w_is_mem = (in_sl == 2'b01) || (in_sl == 2'b10);
  assign w_in_off = in_result[OFFW-1:0];

  // A dword access cannot be performed on a 32-bit bus, so it is reported as misaligned.
  always_comb begin
    w_misal = 1'b0;
    w_bmask = 8'h01;
    case (in_munit)
      2'b00: begin w_misal = 1'b0;                                  w_bmask = 8'h01; end
      2'b01: begin w_misal = in_result[0];                          w_bmask = 8'h03; end
      2'b10: begin w_misal = |in_result[1:0];                       w_bmask = 8'h0F; end
      default: begin w_misal = (XLEN == 32) || (|in_result[2:0]); w_bmask = 8'hFF; end
    endcase
  end

  assign w_shift = mem_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    w_lmask = '1;
    w_sign  = w_shift[XLEN-1];
    case (munit_q)
      2'b00:   begin w_lmask = XLEN'(8'hFF);         w_sign = w_shift[7];      end
      2'b01:   begin w_lmask = XLEN'(16'hFFFF);      w_sign = w_shift[15];     end
      2'b10:   begin w_lmask = XLEN'(32'hFFFF_FFFF); w_sign = w_shift[31];     end
      default: begin w_lmask = '1;                   w_sign = w_shift[XLEN-1]; end
    endcase
  end

  assign w_ext = (w_shift & w_lmask) | ((!uns_q && w_sign) ? ~w_lmask : '0);

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
  logic [CNTW-1:0] cnt_q;

  // REQ is only reachable from IDLE, so clearing in IDLE clears on entry to REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign w_timeout = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                     (cnt_q == CNTW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bwdata_d = bwdata_q;
    strb_d   = strb_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    munit_d  = munit_q;
    uns_d    = uns_q;
    off_d    = off_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          munit_d = in_munit;
          uns_d   = in_unsigned;
          off_d   = w_in_off;
          wdata_d = '0;
          exc_d   = 1'b0;
          cause_d = 2'b00;
          if (!w_is_mem) begin
            state_d = S_DONE;
            wdata_d = in_result;
          end else if (w_misal) begin
            state_d = S_DONE;
            exc_d   = 1'b1;
            cause_d = (in_sl == 2'b10) ? 2'b01 : 2'b10;
          end else begin
            state_d  = S_REQ;
            we_d     = (in_sl == 2'b01);
            addr_d   = {in_result[XLEN-1:OFFW], {OFFW{1'b0}}};
            bwdata_d = in_wmdata << {w_in_off, 3'b000};
            strb_d   = STRB'(w_bmask) << w_in_off;
          end
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          state_d = S_DONE;
          exc_d   = 1'b1;
          cause_d = 2'b11;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_DONE;
          if (mem_resp_err) begin
            exc_d   = 1'b1;
            cause_d = 2'b11;
            wdata_d = '0;
          end else begin
            wdata_d = we_q ? '0 : w_ext;
          end
        end else if (w_timeout) begin
          state_d = S_DONE;
          exc_d   = 1'b1;
          cause_d = 2'b11;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      bwdata_q <= '0;
      strb_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      exc_q    <= 1'b0;
      cause_q  <= 2'b00;
      munit_q  <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bwdata_q <= bwdata_d;
      strb_q   <= strb_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
      munit_q  <= munit_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign out_wdata     = wdata_q;
  assign out_exc       = exc_q;
  assign out_cause     = cause_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = bwdata_q;
  assign mem_req_wstrb = strb_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040895_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | Module   : tb_ysyx_22040895_lsu                                                               |
// | Brief    : Self-checking bench for ysyx_22040895_lsu against a byte-level reference model.    |
// | Revision : 1.0 - initial release                                                              |
// +----------------------------------------------------------------------------------------------+

module tb_ysyx_22040895_lsu;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_unsigned;
  logic [1:0]      in_sl, in_munit;
  logic [XLEN-1:0] in_result, in_wmdata;
  logic            out_valid, out_ready, out_exc;
  logic [XLEN-1:0] out_wdata;
  logic [1:0]      out_cause;
  logic            mem_req_valid, mem_req_ready, mem_req_we;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
  logic [7:0]      mem_req_wstrb;
  logic            mem_resp_valid, mem_resp_err;
  logic [XLEN-1:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040895_lsu #(.XLEN(XLEN), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sl(in_sl), .in_munit(in_munit),
    .in_unsigned(in_unsigned), .in_result(in_result), .in_wmdata(in_wmdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
    .out_exc(out_exc), .out_cause(out_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         bus;
    bit         exc;
    logic [1:0] cause;
    logic [63:0] wdata;
    logic [63:0] addr;
    bit         we;
    logic [7:0] strb;
    logic [63:0] bwdata;
  } exp_t;

  // Reference: operate on individual bytes of the bus word.
  function automatic exp_t model(input logic [1:0] sl, input logic [1:0] munit, input bit uns,
                                 input logic [63:0] res, input logic [63:0] wm,
                                 input logic [63:0] rdata, input bit err);
    exp_t e;
    int size, off;
    logic [63:0] v;
    e.bus = 0; e.exc = 0; e.cause = 2'b00; e.wdata = '0; e.addr = '0;
    e.we = 0; e.strb = '0; e.bwdata = '0;
    size = 1 << munit;
    off  = int'(res[2:0]);
    if (!(sl == 2'b01 || sl == 2'b10)) begin
      e.wdata = res;
      return e;
    end
    if ((off % size) != 0) begin
      e.exc   = 1;
      e.cause = (sl == 2'b10) ? 2'b01 : 2'b10;
      return e;
    end
    e.bus  = 1;
    e.we   = (sl == 2'b01);
    e.addr = res - 64'(off);
    for (int i = 0; i < size; i++) begin
      e.strb[off+i]            = 1'b1;
      e.bwdata[8*(off+i) +: 8] = wm[8*i +: 8];
    end
    if (err) begin
      e.exc   = 1;
      e.cause = 2'b11;
    end else if (!e.we) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!uns && v[8*size-1]) for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.wdata = v;
    end
    return e;
  endfunction

  // Observations from the most recent run_op
  logic [63:0] g_wdata, g_addr, g_bwdata;
  logic [7:0]  g_strb;
  logic [1:0]  g_cause;
  bit          g_exc, g_we, g_saw_req, g_stable, g_busy_ok, g_hold_ok, g_timeout, g_idle_after;
  int          g_lat;

  task automatic run_op(input logic [1:0] sl, input logic [1:0] munit, input bit uns,
                        input logic [63:0] res, input logic [63:0] wm, input logic [63:0] rdata,
                        input bit err, input int req_dly, input int resp_dly, input int hold);
    int  rc, pc;
    bit  hs_pending, hs, sent;
    g_saw_req = 0; g_stable = 1; g_busy_ok = 1; g_hold_ok = 1; g_timeout = 0; g_lat = 0;
    g_addr = '0; g_bwdata = '0; g_strb = '0; g_we = 0; g_idle_after = 0;
    in_valid = 1; in_sl = sl; in_munit = munit; in_unsigned = uns;
    in_result = res; in_wmdata = wm;
    out_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
    @(posedge clk); #1;
    in_valid = 0;
    in_sl = 2'($urandom); in_munit = 2'($urandom); in_unsigned = 1'($urandom);
    in_result = {$urandom, $urandom}; in_wmdata = {$urandom, $urandom};
    g_lat = 1; rc = 0; pc = 0; hs_pending = 0; hs = 0; sent = 0;
    forever begin
      mem_resp_valid = 0;
      if (hs_pending) begin hs = 1; hs_pending = 0; mem_req_ready = 0; end
      if (out_valid) break;
      if (in_ready) g_busy_ok = 0;
      if (mem_req_valid) begin
        if (!g_saw_req) begin
          g_saw_req = 1; g_addr = mem_req_addr; g_bwdata = mem_req_wdata;
          g_strb = mem_req_wstrb; g_we = mem_req_we;
        end else if (mem_req_addr !== g_addr || mem_req_wdata !== g_bwdata ||
                     mem_req_wstrb !== g_strb || mem_req_we !== g_we) begin
          g_stable = 0;
        end
        if (rc >= req_dly) begin mem_req_ready = 1; hs_pending = 1; end
        else begin mem_req_ready = 0; rc++; end
      end else if (hs && !sent) begin
        if (pc >= resp_dly) begin
          mem_resp_valid = 1; mem_resp_rdata = rdata; mem_resp_err = err; sent = 1;
        end else begin
          mem_resp_rdata = {$urandom, $urandom}; mem_resp_err = 1'($urandom); pc++;
        end
      end
      if (g_lat >= 400) begin g_timeout = 1; break; end
      @(posedge clk); #1;
      g_lat++;
    end
    mem_resp_valid = 0; mem_req_ready = 0;
    if (g_timeout) begin
      rst = 1; @(posedge clk); #1; rst = 0;
      return;
    end
    g_wdata = out_wdata; g_exc = out_exc; g_cause = out_cause;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!out_valid || out_wdata !== g_wdata || out_exc !== g_exc || out_cause !== g_cause)
        g_hold_ok = 0;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    g_idle_after = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_exc, mem_req_valid, mem_req_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {in_ready, out_valid, out_exc, mem_req_valid, mem_req_we});
    end
    n_checks++;
    if (out_wdata !== '0 || out_cause !== 2'b00) begin
      n_fail++; $display("FAIL reset_out: got wdata %h cause %b expected 0", out_wdata, out_cause);
    end
    n_checks++;
    if (mem_req_addr !== '0 || mem_req_wdata !== '0 || mem_req_wstrb !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h wstrb %h expected 0",
               mem_req_addr, mem_req_wdata, mem_req_wstrb);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    run_op(2'b10, 2'b10, 0, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0, 0);
    n_checks++;
    if (g_addr !== 64'h8000_0000) begin
      n_fail++; $display("FAIL lw_addr: got %h expected 0000000080000000", g_addr);
    end
    n_checks++;
    if (g_wdata !== 64'hFFFF_FFFF_8765_4321 || g_exc !== 0) begin
      n_fail++; $display("FAIL lw_data: got %h exc %0d expected ffffffff87654321 exc 0", g_wdata, g_exc);
    end
    n_checks++;
    if (g_lat !== 3 || g_we !== 0) begin
      n_fail++; $display("FAIL lw_lat: got lat %0d we %0d expected lat 3 we 0", g_lat, g_we);
    end
  endtask

  task automatic test_store_byte();
    run_op(2'b01, 2'b00, 0, 64'h8000_0003, 64'hAB, 64'h0, 0, 1, 0, 0);
    n_checks++;
    if (g_strb !== 8'h08 || g_bwdata[31:24] !== 8'hAB || g_we !== 1) begin
      n_fail++;
      $display("FAIL sb_bus: got strb %h byte %h we %0d expected strb 08 byte ab we 1",
               g_strb, g_bwdata[31:24], g_we);
    end
    n_checks++;
    if (g_exc !== 0 || g_wdata !== '0 || g_lat !== 4) begin
      n_fail++;
      $display("FAIL sb_result: got exc %0d wdata %h lat %0d expected exc 0 wdata 0 lat 4",
               g_exc, g_wdata, g_lat);
    end
  endtask

  task automatic test_misaligned();
    run_op(2'b10, 2'b01, 0, 64'h8000_0001, 64'h0, 64'h0, 0, 0, 0, 0);
    n_checks++;
    if (g_exc !== 1 || g_cause !== 2'b01 || g_lat !== 1 || g_saw_req !== 0) begin
      n_fail++;
      $display("FAIL lh_misal: got exc %0d cause %b lat %0d req %0d expected 1 01 1 0",
               g_exc, g_cause, g_lat, g_saw_req);
    end
    run_op(2'b01, 2'b10, 0, 64'h8000_0006, 64'h1, 64'h0, 0, 0, 0, 0);
    n_checks++;
    if (g_exc !== 1 || g_cause !== 2'b10 || g_lat !== 1 || g_saw_req !== 0) begin
      n_fail++;
      $display("FAIL sw_misal: got exc %0d cause %b lat %0d req %0d expected 1 10 1 0",
               g_exc, g_cause, g_lat, g_saw_req);
    end
  endtask

  task automatic test_passthrough();
    run_op(2'b00, 2'b11, 0, 64'h1234, 64'h0, 64'h0, 0, 0, 0, 3);
    n_checks++;
    if (g_lat !== 1 || g_wdata !== 64'h1234 || g_exc !== 0) begin
      n_fail++; $display("FAIL pass: got lat %0d wdata %h exc %0d expected 1 1234 0", g_lat, g_wdata, g_exc);
    end
    n_checks++;
    if (!g_hold_ok || !g_idle_after) begin
      n_fail++; $display("FAIL pass_hold: got hold %0d idle %0d expected 1 1", g_hold_ok, g_idle_after);
    end
    run_op(2'b11, 2'b01, 0, 64'hDEAD_0001, 64'h0, 64'h0, 0, 0, 0, 0);
    n_checks++;
    if (g_lat !== 1 || g_wdata !== 64'hDEAD_0001 || g_exc !== 0 || g_saw_req !== 0) begin
      n_fail++; $display("FAIL sl11_pass: got lat %0d wdata %h exc %0d expected 1 dead0001 0", g_lat, g_wdata, g_exc);
    end
  endtask

  task automatic test_bus_error_stall();
    run_op(2'b10, 2'b11, 0, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 1, 5, 0, 0);
    n_checks++;
    if (!g_stable || g_lat !== 8) begin
      n_fail++; $display("FAIL err_stall: got stable %0d lat %0d expected 1 8", g_stable, g_lat);
    end
    n_checks++;
    if (g_exc !== 1 || g_cause !== 2'b11 || g_wdata !== '0) begin
      n_fail++; $display("FAIL err_cause: got exc %0d cause %b wdata %h expected 1 11 0", g_exc, g_cause, g_wdata);
    end
  endtask

  task automatic test_reset_mid_op();
    bit quiet;
    in_valid = 1; in_sl = 2'b10; in_munit = 2'b11; in_unsigned = 0;
    in_result = 64'h8000_0010; in_wmdata = '0;
    @(posedge clk); #1;
    in_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    n_checks++;
    if (in_ready !== 0 || mem_req_valid !== 0 || out_valid !== 0) begin
      n_fail++; $display("FAIL mid_wait: got ready %0d req %0d out %0d expected 0 0 0", in_ready, mem_req_valid, out_valid);
    end
    rst = 1; #1;
    n_checks++;
    if (in_ready !== 1 || mem_req_valid !== 0) begin
      n_fail++; $display("FAIL mid_async: got ready %0d req %0d expected 1 0", in_ready, mem_req_valid);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    mem_resp_valid = 1; mem_resp_rdata = 64'h55; mem_resp_err = 0;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 0 || in_ready !== 1 || mem_req_valid !== 0) quiet = 0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL mid_quiet: got quiet %0d expected 1", quiet);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0]  sl, mu;
    logic [63:0] res, wm, rd, m;
    bit          uns, err;
    int          rd_dly, rs_dly;
    for (int n = 0; n < 60; n++) begin
      sl = 2'($urandom); mu = 2'($urandom); uns = 1'($urandom);
      res = {$urandom, $urandom}; wm = {$urandom, $urandom}; rd = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) res = res & ~64'((1 << mu) - 1);
      err = ($urandom_range(0, 7) == 0);
      rd_dly = $urandom_range(0, 3); rs_dly = $urandom_range(0, 3);
      e = model(sl, mu, uns, res, wm, rd, err);
      run_op(sl, mu, uns, res, wm, rd, err, rd_dly, rs_dly, $urandom_range(0, 2));
      n_checks++;
      if (g_timeout) begin
        n_fail++; $display("FAIL rnd_timeout[%0d]: got no out_valid within 400 cycles expected done", n);
        continue;
      end
      if (g_exc !== e.exc || g_cause !== e.cause || g_wdata !== e.wdata) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: got exc %0d cause %b wdata %h expected %0d %b %h",
                 n, g_exc, g_cause, g_wdata, e.exc, e.cause, e.wdata);
      end
      n_checks++;
      if (g_saw_req !== e.bus || !g_busy_ok || !g_hold_ok || !g_idle_after) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: got req %0d busy_ok %0d hold %0d idle %0d expected %0d 1 1 1",
                 n, g_saw_req, g_busy_ok, g_hold_ok, g_idle_after, e.bus);
      end
      n_checks++;
      if (g_lat !== (e.bus ? 3 + rd_dly + rs_dly : 1)) begin
        n_fail++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", n, g_lat, e.bus ? 3 + rd_dly + rs_dly : 1);
      end
      if (e.bus) begin
        m = '0;
        for (int i = 0; i < 8; i++) if (e.strb[i]) m[8*i +: 8] = 8'hFF;
        n_checks++;
        if (g_addr !== e.addr || g_we !== e.we || g_strb !== e.strb ||
            (g_bwdata & m) !== e.bwdata || !g_stable) begin
          n_fail++;
          $display("FAIL rnd_bus[%0d]: got addr %h we %0d strb %h wdata %h stable %0d expected %h %0d %h %h 1",
                   n, g_addr, g_we, g_strb, g_bwdata & m, g_stable, e.addr, e.we, e.strb, e.bwdata);
        end
      end
    end
  endtask

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_op(2'b10, 2'b10, 0, 64'h8000_0020, 64'h0, 64'h0, 0, 100000, 0, 0);
    n_checks++;
    if (g_timeout || g_exc !== 1 || g_cause !== 2'b11 || g_lat < 255 || g_lat > 257) begin
      n_fail++;
      $display("FAIL timeout: got tmo %0d exc %0d cause %b lat %0d expected 0 1 11 ~256",
               g_timeout, g_exc, g_cause, g_lat);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_sl = 0; in_munit = 0; in_unsigned = 0;
    in_result = '0; in_wmdata = '0; out_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_misaligned();
    test_passthrough();
    test_bus_error_stall();
    test_reset_mid_op();
    test_back_to_back();
`ifdef YSYX_22040895_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
